// File: rtl/fft_bfly_sequencer.sv
// Address and twiddle sequencer for an in-place radix-2 DIT 32-point FFT.
// Walks 5 stages x 16 butterflies and presents each butterfly's sample-memory
// address pair and sign-magnitude twiddle factor over a valid/ready handshake.
// Optional feature macro: FFT_STAGE_GAP_EN inserts STAGE_GAP idle cycles
// between stages so the butterfly pipeline can write back before the next
// stage reads.
// The twiddle ROM holds magnitudes rounded for FIX_BIT = 7; N = 32 is fixed.
module fft_bfly_sequencer #(
  parameter int unsigned BITS      = 16,
  parameter int unsigned FIX_BIT   = 7,
  parameter int unsigned LOG2N     = 5,
  parameter int unsigned STAGE_GAP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [BITS-1:0]  tw_re,
  output logic [BITS-1:0]  tw_im,
  output logic [2:0]       stage,
  output logic             last
);

  localparam int unsigned K_W   = LOG2N - 1;
  localparam int unsigned M_W   = LOG2N - 1;
  localparam int unsigned MAG_W = FIX_BIT + 1;
  localparam int unsigned GW    = (STAGE_GAP < 2) ? 1 : $clog2(STAGE_GAP + 1);

  localparam logic [2:0]     STAGE_LAST = 3'(LOG2N - 1);
  localparam logic [K_W-1:0] K_LAST     = '1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state;
  logic [K_W-1:0] k_q;

  logic           k_wrap;
  logic           at_last;
  logic [2:0]     nxt_stage;
  logic [K_W-1:0] nxt_k;
  logic [2:0]     sel_stage;
  logic [K_W-1:0] sel_k;
  logic           sel_last;

  logic [LOG2N-1:0] span;
  logic [K_W-1:0]   mask;
  logic [K_W-1:0]   pos;
  logic [K_W-1:0]   grp;
  logic [M_W-1:0]   m;
  logic [LOG2N-1:0] addr_a_c;
  logic [LOG2N-1:0] addr_b_c;

  logic             re_neg;
  logic             im_neg;
  logic [MAG_W-1:0] re_mag;
  logic [MAG_W-1:0] im_mag;
  logic [BITS-1:0]  tw_re_c;
  logic [BITS-1:0]  tw_im_c;

`ifdef FFT_STAGE_GAP_EN
  logic [GW-1:0] gap_cnt;
`else
  // Keeps the gap length referenced when the gap logic is compiled out.
  logic [GW-1:0] unused_gap;
  assign unused_gap = GW'(STAGE_GAP);
`endif

  // Position of the butterfly to present next (fresh run from IDLE, else advance).
  always_comb begin
    k_wrap    = (k_q == K_LAST);
    at_last   = k_wrap && (stage == STAGE_LAST);
    nxt_k     = k_wrap ? '0 : k_q + K_W'(1);
    nxt_stage = k_wrap ? stage + 3'd1 : stage;
    sel_stage = nxt_stage;
    sel_k     = nxt_k;
    if (state == IDLE) begin
      sel_stage = '0;
      sel_k     = '0;
    end
    sel_last = (sel_stage == STAGE_LAST) && (sel_k == K_LAST);
  end

  // Address pair and twiddle index: insert a zero bit at position 'stage' of k.
  always_comb begin
    span     = LOG2N'(1) << sel_stage;
    mask     = K_W'(span - LOG2N'(1));
    pos      = sel_k & mask;
    grp      = sel_k >> sel_stage;
    addr_a_c = (LOG2N'(grp) << (sel_stage + 3'd1)) | LOG2N'(pos);
    addr_b_c = addr_a_c + span;
    m        = M_W'(pos << (3'(K_W) - sel_stage));
  end

  // Twiddle ROM: W^m = cos(2*pi*m/32) - j*sin(2*pi*m/32), magnitudes in Q.7.
  always_comb begin
    re_neg = 1'b0;
    im_neg = 1'b1;
    re_mag = '0;
    im_mag = '0;
    case (m)
      4'd0:  begin re_mag = MAG_W'(128); im_mag = MAG_W'(0);   im_neg = 1'b0; end
      4'd1:  begin re_mag = MAG_W'(126); im_mag = MAG_W'(25);  end
      4'd2:  begin re_mag = MAG_W'(118); im_mag = MAG_W'(49);  end
      4'd3:  begin re_mag = MAG_W'(106); im_mag = MAG_W'(71);  end
      4'd4:  begin re_mag = MAG_W'(91);  im_mag = MAG_W'(91);  end
      4'd5:  begin re_mag = MAG_W'(71);  im_mag = MAG_W'(106); end
      4'd6:  begin re_mag = MAG_W'(49);  im_mag = MAG_W'(118); end
      4'd7:  begin re_mag = MAG_W'(25);  im_mag = MAG_W'(126); end
      4'd8:  begin re_mag = MAG_W'(0);   im_mag = MAG_W'(128); end
      4'd9:  begin re_mag = MAG_W'(25);  im_mag = MAG_W'(126); re_neg = 1'b1; end
      4'd10: begin re_mag = MAG_W'(49);  im_mag = MAG_W'(118); re_neg = 1'b1; end
      4'd11: begin re_mag = MAG_W'(71);  im_mag = MAG_W'(106); re_neg = 1'b1; end
      4'd12: begin re_mag = MAG_W'(91);  im_mag = MAG_W'(91);  re_neg = 1'b1; end
      4'd13: begin re_mag = MAG_W'(106); im_mag = MAG_W'(71);  re_neg = 1'b1; end
      4'd14: begin re_mag = MAG_W'(118); im_mag = MAG_W'(49);  re_neg = 1'b1; end
      4'd15: begin re_mag = MAG_W'(126); im_mag = MAG_W'(25);  re_neg = 1'b1; end
      default: ;
    endcase
    tw_re_c = {re_neg, (BITS-1)'(re_mag)};
    tw_im_c = {im_neg, (BITS-1)'(im_mag)};
  end

  // Sequencer FSM with registered handshake, address and twiddle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tw_re     <= '0;
      tw_im     <= '0;
      last      <= 1'b0;
`ifdef FFT_STAGE_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            stage     <= sel_stage;
            k_q       <= sel_k;
            addr_a    <= addr_a_c;
            addr_b    <= addr_b_c;
            tw_re     <= tw_re_c;
            tw_im     <= tw_im_c;
            last      <= sel_last;
          end
        end
        RUN: begin
`ifdef FFT_STAGE_GAP_EN
          if (!out_valid) begin
            if (gap_cnt <= GW'(1)) out_valid <= 1'b1;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          end else
`endif
          if (out_valid && out_ready) begin
            if (at_last) begin
              state     <= FIN;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              last      <= 1'b0;
            end else begin
              stage  <= sel_stage;
              k_q    <= sel_k;
              addr_a <= addr_a_c;
              addr_b <= addr_b_c;
              tw_re  <= tw_re_c;
              tw_im  <= tw_im_c;
              last   <= sel_last;
`ifdef FFT_STAGE_GAP_EN
              if (k_wrap && (STAGE_GAP != 0)) begin
                out_valid <= 1'b0;
                gap_cnt   <= GW'(STAGE_GAP);
              end
`endif
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed bench for fft_bfly_sequencer: table of hand-computed butterflies,
// full-stream model check, backpressure, ignored START and async reset abort.
module tb_fft_bfly_sequencer;

`ifdef FFT_STAGE_GAP_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic        busy, done, out_valid, last;
  logic [4:0]  addr_a, addr_b;
  logic [15:0] tw_re, tw_im;
  logic [2:0]  stage;

  always #5 clk = ~clk;

  fft_bfly_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .addr_a(addr_a),
    .addr_b(addr_b), .tw_re(tw_re), .tw_im(tw_im), .stage(stage), .last(last)
  );

  logic [45:0] cur_bfly;
  assign cur_bfly = {addr_a, addr_b, tw_re, tw_im, stage, last};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Transfer monitor and gap-length tracker, sampled on the falling edge.
  int xfer_cnt = 0;
  int run_base = 0;
  int done_cnt = 0;
  int gap_runs = 0;
  int gap_cyc  = 0;
  int gap_min  = 1000;
  int gap_max  = 0;
  int cur_run  = 0;
  logic [45:0] cap [80];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if ((xfer_cnt - run_base) >= 0 && (xfer_cnt - run_base) < 80)
        cap[xfer_cnt - run_base] = cur_bfly;
      xfer_cnt++;
    end
    if (done) done_cnt++;
    if (busy && !out_valid) begin
      cur_run++;
      gap_cyc++;
    end else if (cur_run != 0) begin
      gap_runs++;
      if (cur_run < gap_min) gap_min = cur_run;
      if (cur_run > gap_max) gap_max = cur_run;
      cur_run = 0;
    end
  end

  // Hand-computed twiddles {re, im} for m = 0..15 at 1.0 = 128.
  function automatic logic [31:0] tw_of(input int m);
    case (m)
      0:  return {16'h0080, 16'h0000};
      1:  return {16'h007E, 16'h8019};
      2:  return {16'h0076, 16'h8031};
      3:  return {16'h006A, 16'h8047};
      4:  return {16'h005B, 16'h805B};
      5:  return {16'h0047, 16'h806A};
      6:  return {16'h0031, 16'h8076};
      7:  return {16'h0019, 16'h807E};
      8:  return {16'h0000, 16'h8080};
      9:  return {16'h8019, 16'h807E};
      10: return {16'h8031, 16'h8076};
      11: return {16'h8047, 16'h806A};
      12: return {16'h805B, 16'h805B};
      13: return {16'h806A, 16'h8047};
      14: return {16'h8076, 16'h8031};
      default: return {16'h807E, 16'h8019};
    endcase
  endfunction

  // Expected butterfly for transfer i of a sequence, from the group/position formula.
  function automatic logic [45:0] model(input int i);
    int s, k, h, pos, grp, a, b, m;
    s = i / 16;
    k = i % 16;
    h = 1;
    repeat (s) h = h * 2;
    pos = k % h;
    grp = k / h;
    a = grp * 2 * h + pos;
    b = a + h;
    m = pos * (16 / h);
    return {5'(a), 5'(b), tw_of(m), 3'(s), (i == 79)};
  endfunction

  typedef struct {
    int          s;
    int          k;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] re;
    logic [15:0] im;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq();
    start    = 1'b1;
    run_base = xfer_cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, " transfers"}, 64'(xfer_cnt - run_base), 64'd80);
    for (int i = 0; i < 80; i++)
      chk($sformatf("%s xfer %0d", tag, i), 64'(cap[i]), 64'(model(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base_done;
    logic [45:0] hold;

    tbl[0]  = '{0, 0,  5'd0,  5'd1,  16'h0080, 16'h0000};
    tbl[1]  = '{0, 15, 5'd30, 5'd31, 16'h0080, 16'h0000};
    tbl[2]  = '{1, 1,  5'd1,  5'd3,  16'h0000, 16'h8080};
    tbl[3]  = '{1, 2,  5'd4,  5'd6,  16'h0080, 16'h0000};
    tbl[4]  = '{1, 7,  5'd13, 5'd15, 16'h0000, 16'h8080};
    tbl[5]  = '{2, 3,  5'd3,  5'd7,  16'h805B, 16'h805B};
    tbl[6]  = '{2, 6,  5'd10, 5'd14, 16'h0000, 16'h8080};
    tbl[7]  = '{3, 5,  5'd5,  5'd13, 16'h8031, 16'h8076};
    tbl[8]  = '{3, 7,  5'd7,  5'd15, 16'h8076, 16'h8031};
    tbl[9]  = '{3, 9,  5'd17, 5'd25, 16'h0076, 16'h8031};
    tbl[10] = '{4, 1,  5'd1,  5'd17, 16'h007E, 16'h8019};
    tbl[11] = '{4, 4,  5'd4,  5'd20, 16'h005B, 16'h805B};
    tbl[12] = '{4, 5,  5'd5,  5'd21, 16'h0047, 16'h806A};
    tbl[13] = '{4, 9,  5'd9,  5'd25, 16'h8019, 16'h807E};
    tbl[14] = '{4, 13, 5'd13, 5'd29, 16'h806A, 16'h8047};
    tbl[15] = '{4, 15, 5'd15, 5'd31, 16'h807E, 16'h8019};

    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({busy, done, out_valid, cur_bfly}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("idle busy/valid", 64'({busy, out_valid, done}), 64'd0);

    // Run 1: full sequence with ready held high.
    tick();
    out_ready = 1'b1;
    base_done = done_cnt;
    start_seq();
    @(negedge clk);
    chk("first valid/busy", 64'({out_valid, busy}), 64'b11);
    chk("first butterfly", 64'(cur_bfly), {18'd0, 5'd0, 5'd1, 16'h0080, 16'h0000, 3'd0, 1'b0});
    wait_done(300, cyc);
    chk("run1 done latency", 64'(cyc), 64'(80 + 4 * GAP));
    chk("run1 busy at done", 64'(busy), 64'd0);
    #1;
    chk("run1 done count", 64'(done_cnt - base_done), 64'd1);
    @(negedge clk);
    chk("run1 done pulse width", 64'(done), 64'd0);
    check_stream("run1");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tbl s%0d k%0d", tbl[i].s, tbl[i].k),
          64'(cap[tbl[i].s * 16 + tbl[i].k][45:1]),
          64'({tbl[i].a, tbl[i].b, tbl[i].re, tbl[i].im, 3'(tbl[i].s)}));
    end
`ifdef FFT_STAGE_GAP_EN
    chk("run1 gap runs", 64'(gap_runs), 64'd4);
    chk("run1 gap min", 64'(gap_min), 64'(GAP));
    chk("run1 gap max", 64'(gap_max), 64'(GAP));
`else
    chk("run1 gap cycles", 64'(gap_cyc), 64'd0);
`endif

    // Run 2: START during RUN, 5-cycle stall at stage 3 k 7, START during FIN.
    tick();
    base_done = done_cnt;
    start_seq();
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34 + 3 * GAP) tick();
    out_ready = 1'b0;
    @(negedge clk);
    hold = cur_bfly;
    chk("stall entry valid", 64'(out_valid), 64'd1);
    chk("stall entry bfly", 64'(cur_bfly), 64'(model(55)));
    repeat (4) begin
      @(negedge clk);
      chk("stall hold", 64'({out_valid, cur_bfly}), 64'({1'b1, hold}));
    end
    tick();
    out_ready = 1'b1;
    wait_done(300, cyc);
    chk("run2 done latency", 64'(cyc), 64'(26 + GAP));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("run2 idle after fin start", 64'({busy, out_valid}), 64'd0);
    chk("run2 done count", 64'(done_cnt - base_done), 64'd1);
    check_stream("run2");

    // Run 3: async reset mid stage 2 aborts without DONE, then a clean restart.
    tick();
    base_done = done_cnt;
    start_seq();
    repeat (40 + 2 * GAP) tick();
    @(negedge clk);
    chk("pre-reset bfly", 64'({out_valid, cur_bfly}), 64'({1'b1, model(40)}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy, done, out_valid, cur_bfly}), 64'd0);
    repeat (3) @(negedge clk);
    chk("no done on abort", 64'(done_cnt - base_done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    base_done = done_cnt;
    start_seq();
    @(negedge clk);
    chk("restart first bfly", 64'({out_valid, cur_bfly}), 64'({1'b1, model(0)}));
    wait_done(300, cyc);
    chk("run3 done latency", 64'(cyc), 64'(80 + 4 * GAP));
    #1;
    chk("run3 done count", 64'(done_cnt - base_done), 64'd1);
    check_stream("run3");
`ifdef FFT_STAGE_GAP_EN
    chk("final gap min", 64'(gap_min), 64'(GAP));
    chk("final gap max", 64'(gap_max), 64'(GAP));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
